// File: rtl/tx_frame_module.sv
// UART transmitter: start, 8 data bits LSB first, parity, stop; internal baud divider.
// Tx_En_Sig low freezes every register; RST_n is asynchronous and active-low.
module tx_frame_module #(
    parameter int unsigned BPS_DIV    = 434,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic       CLK,
    input  logic       RST_n,
    input  logic       Tx_En_Sig,
    input  logic       Tx_Start_Sig,
    input  logic [7:0] Tx_Data,
    output logic       Tx_Pin_Out,
    output logic       Tx_Busy_Sig,
    output logic       Tx_Done_Sig
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_DONE
    } state_t;

    localparam logic [15:0] LP_LAST = 16'(BPS_DIV - 1);
    localparam logic        LP_ODD  = (PARITY_ODD != 0);

    state_t      r_state;
    logic [15:0] r_cnt;
    logic [2:0]  r_idx;
    logic [7:0]  r_data;
    logic        r_parity;
    logic        r_line;
    logic        r_busy;
    logic        r_done;

    logic        w_bit_end;
    logic        w_par;
    logic [2:0]  w_next_idx;

    assign w_bit_end  = (r_cnt == LP_LAST);
    assign w_par      = (^Tx_Data) ^ LP_ODD;
    assign w_next_idx = r_idx + 3'd1;

    assign Tx_Pin_Out  = r_line;
    assign Tx_Busy_Sig = r_busy;
    assign Tx_Done_Sig = r_done;

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_data   <= '0;
            r_parity <= 1'b0;
            r_line   <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else if (Tx_En_Sig) begin
            unique case (r_state)
                // DONE also accepts a pending request so back-to-back frames repeat every 11*BPS_DIV+1 cycles.
                S_IDLE, S_DONE: begin
                    r_cnt   <= '0;
                    r_line  <= 1'b1;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                    if (Tx_Start_Sig) begin
                        r_data   <= Tx_Data;
                        r_parity <= w_par;
                        r_idx    <= '0;
                        r_line   <= 1'b0;
                        r_busy   <= 1'b1;
                        r_state  <= S_START;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_idx   <= '0;
                        r_line  <= r_data[0];
                        r_state <= S_DATA;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (r_idx == 3'd7) begin
                            r_line  <= r_parity;
                            r_state <= S_PARITY;
                        end else begin
                            r_idx  <= w_next_idx;
                            r_line <= r_data[w_next_idx];
                        end
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_PARITY: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_line  <= 1'b1;
                        r_state <= S_STOP;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_STOP: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_line  <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                    r_line  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tx_frame_module.sv
// Directed bench for tx_frame_module: two instances (even/odd parity) at BPS_DIV = 4.
// Inputs change and outputs are sampled on the falling edge.
module tb_tx_frame_module;

    logic       CLK = 1'b0;
    logic       RST_n;
    logic       en;
    logic       start_e, start_o;
    logic [7:0] data_e, data_o;
    logic       line_e, busy_e, done_e;
    logic       line_o, busy_o, done_o;

    int n_vec = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    tx_frame_module #(.BPS_DIV(4), .PARITY_ODD(0)) dut_e (
        .CLK          (CLK),
        .RST_n        (RST_n),
        .Tx_En_Sig    (en),
        .Tx_Start_Sig (start_e),
        .Tx_Data      (data_e),
        .Tx_Pin_Out   (line_e),
        .Tx_Busy_Sig  (busy_e),
        .Tx_Done_Sig  (done_e)
    );

    tx_frame_module #(.BPS_DIV(4), .PARITY_ODD(1)) dut_o (
        .CLK          (CLK),
        .RST_n        (RST_n),
        .Tx_En_Sig    (en),
        .Tx_Start_Sig (start_o),
        .Tx_Data      (data_o),
        .Tx_Pin_Out   (line_o),
        .Tx_Busy_Sig  (busy_o),
        .Tx_Done_Sig  (done_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic drv(input bit odd, input logic s, input logic [7:0] d);
        if (odd) begin
            start_o = s;
            data_o  = d;
        end else begin
            start_e = s;
            data_e  = d;
        end
    endtask

    // {line, busy, done} of the selected instance
    function automatic logic [2:0] obs(input bit odd);
        return odd ? {line_o, busy_o, done_o} : {line_e, busy_e, done_e};
    endfunction

    task automatic start_frame(input bit odd, input logic [7:0] d);
        drv(odd, 1'b1, d);
        @(negedge CLK);
    endtask

    // Entered at the first falling edge after the accepting edge; returns one cycle after Done.
    task automatic check_frame(input bit odd, input logic [7:0] d, input logic exp_par,
                               input bit hold, input int frz_at, input logic [7:0] next_d);
        logic [10:0] bits;
        logic [2:0]  o;
        bits = {1'b1, exp_par, d, 1'b0};
        for (int m = 0; m < 44; m++) begin
            o = obs(odd);
            check($sformatf("%s m%0d bit", odd ? "odd" : "even", m), {29'd0, o}, {29'd0, bits[m/4], 2'b10});
            if (hold) drv(odd, 1'b1, 8'($urandom));
            else      drv(odd, (m % 7) == 3, 8'($urandom));
            if (m == frz_at) begin
                en = 1'b0;
                for (int f = 0; f < 7; f++) begin
                    @(negedge CLK);
                    o = obs(odd);
                    check($sformatf("frozen f%0d", f), {29'd0, o}, {29'd0, bits[m/4], 2'b10});
                end
                en = 1'b1;
            end
            @(negedge CLK);
        end
        check("done pulse", {29'd0, obs(odd)}, 32'b111);
        if (hold) drv(odd, 1'b1, next_d);
        else      drv(odd, 1'b0, 8'h00);
        @(negedge CLK);
    endtask

    task automatic check_idle(input bit odd, input string tag);
        check(tag, {29'd0, obs(odd)}, 32'b100);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        RST_n = 1'b0;
        en    = 1'b1;
        drv(0, 1'b0, 8'h00);
        drv(1, 1'b0, 8'h00);
        repeat (3) @(negedge CLK);
        RST_n = 1'b1;

        for (int i = 0; i < 100; i++) begin
            check_idle(0, "reset idle even");
            check_idle(1, "reset idle odd");
            @(negedge CLK);
        end

        // 0x35 even parity: bits 1,0,1,0,1,1,0,0 parity 0
        start_frame(0, 8'h35);
        check_frame(0, 8'h35, 1'b0, 0, -1, 8'h00);
        check_idle(0, "after 0x35");
        @(negedge CLK);

        start_frame(1, 8'h01);
        check_frame(1, 8'h01, 1'b0, 0, -1, 8'h00);
        check_idle(1, "after odd 0x01");
        @(negedge CLK);
        start_frame(1, 8'h00);
        check_frame(1, 8'h00, 1'b1, 0, -1, 8'h00);
        check_idle(1, "after odd 0x00");
        @(negedge CLK);
        start_frame(0, 8'h01);
        check_frame(0, 8'h01, 1'b1, 0, -1, 8'h00);
        check_idle(0, "after even 0x01");
        @(negedge CLK);

        // Start held high: 0xA5 then 0x3C, 45 cycles apart
        start_frame(0, 8'hA5);
        check_frame(0, 8'hA5, 1'b0, 1, -1, 8'h3C);
        check_frame(0, 8'h3C, 1'b0, 0, -1, 8'h00);
        check_idle(0, "after back-to-back");
        @(negedge CLK);

        // Enable dropped for 7 cycles during data bit 3
        start_frame(0, 8'h96);
        check_frame(0, 8'h96, 1'b0, 0, 17, 8'h00);
        check_idle(0, "after freeze");
        @(negedge CLK);

        // Reset asserted during the parity bit
        start_frame(0, 8'hC3);
        drv(0, 1'b0, 8'h00);
        repeat (37) @(negedge CLK);
        check("pre-reset parity", {29'd0, obs(0)}, 32'b010);
        #2 RST_n = 1'b0;
        #1 check("async reset", {29'd0, obs(0)}, 32'b100);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check_idle(0, "in reset");
        end
        RST_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            check_idle(0, "post reset");
        end
        start_frame(0, 8'h5A);
        check_frame(0, 8'h5A, 1'b0, 0, -1, 8'h00);
        check_idle(0, "after 0x5A");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/tx_frame_module.md
# tx_frame_module

UART transmit controller that serializes one byte per request onto `Tx_Pin_Out`. It is the transmit-side counterpart of the receive control path and uses the same 11-bit frame: start bit, 8 data bits LSB first, one parity bit, one stop bit. Baud timing comes from an internal divider, so no external bps module is needed. The block sits between the user logic that supplies bytes and the board TX pin.

## Interface
- `BPS_DIV`, 434: CLK cycles per bit (50 MHz / 115200). Legal range 2..65535.
- `PARITY_ODD`, 0: 0 = even parity, 1 = odd parity, computed over the 8 data bits.
- `CLK`  in  1  system clock.
- `RST_n`  in  1  reset, asynchronous, active-low.
- `Tx_En_Sig`  in  1  module enable. When low, all internal state freezes.
- `Tx_Start_Sig`  in  1  transmit request, sampled only in IDLE.
- `Tx_Data`  in  8  byte to send, captured on the accepting edge.
- `Tx_Pin_Out`  out  1  serial line, registered, idles high.
- `Tx_Busy_Sig`  out  1  high whenever state is not IDLE.
- `Tx_Done_Sig`  out  1  one-cycle pulse after the stop bit completes.

## Operation
- States: IDLE, START, DATA, PARITY, STOP, DONE.
- Registers: 16-bit baud counter `cnt`, 3-bit bit index, 8-bit shift/hold register, parity register.
- IDLE behaviour:
  - `Tx_Pin_Out` = 1, `cnt` = 0.
  - If `Tx_En_Sig` and `Tx_Start_Sig` are both high: latch `Tx_Data` and parity (`^Tx_Data ^ PARITY_ODD`), drive the line low, go to START.
  - `Tx_Start_Sig` while not in IDLE is ignored. There is no queuing.
- Baud counting in START/DATA/PARITY/STOP:
  - `cnt` increments each enabled cycle.
  - At `cnt == BPS_DIV-1`: `cnt` wraps to 0 and the bit ends.
- Bit transitions:
  - START end: drive data bit 0, go to DATA.
  - DATA end: advance the index. After index 7, drive parity and go to PARITY.
  - PARITY end: drive 1, go to STOP.
  - STOP end: go to DONE.
- DONE:
  - `Tx_Done_Sig` = 1 and line = 1.
  - Next enabled cycle goes to IDLE with `Tx_Done_Sig` = 0.
- `Tx_Data` changes after the accepting edge have no effect on the current frame.
- `Tx_En_Sig` low: every register holds its value (state, `cnt`, line level, and `Tx_Done_Sig` if in DONE). Operation resumes exactly where it stopped.
- Reset, at any time including mid-frame:
  - Outputs: `Tx_Pin_Out` = 1, `Tx_Busy_Sig` = 0, `Tx_Done_Sig` = 0.
  - Internal: state IDLE, `cnt` = 0, data and parity registers = 0.
  - Any partial frame is truncated and the line returns high immediately.

## Timing
- Let T0 be the accepting edge.
- Line is low from T0. Bit k (k = 0 start, 1..8 data, 9 parity, 10 stop) spans edges [T0 + k·BPS_DIV, T0 + (k+1)·BPS_DIV).
- `Tx_Busy_Sig` rises at T0 and falls at T0 + 11·BPS_DIV + 1.
- `Tx_Done_Sig` is high for the single cycle between T0 + 11·BPS_DIV and T0 + 11·BPS_DIV + 1.
- Earliest next accepting edge is T0 + 11·BPS_DIV + 1. Back-to-back frame period is 11·BPS_DIV + 1 cycles.
- All cycle counts above assume `Tx_En_Sig` is continuously high. Disabled cycles stretch the timeline 1:1.
- Start held high continuously is accepted again on the first IDLE cycle.

## Test plan
- Reset release with no stimulus → `Tx_Pin_Out` = 1, Busy = 0, Done = 0 for 100 cycles.
- BPS_DIV = 4, PARITY_ODD = 0, send 0x35 → line 0, then 1,0,1,0,1,1,0,0, then parity 0, then stop 1. Each level lasts exactly 4 cycles. Done pulses once at T0 + 44. Busy spans 45 cycles.
- PARITY_ODD = 1, send 0x01 → parity bit = 0. Send 0x00 → parity bit = 1. With PARITY_ODD = 0, send 0x01 → parity bit = 1.
- Hold Start high with Data changing every cycle → frames 0xA5 and then a second byte are sent back-to-back, 45 cycles apart. Mid-frame Data changes and re-pulsed Start do not alter the frame.
- Drop `Tx_En_Sig` for 7 cycles during data bit 3 → line level and Busy are frozen. The frame completes 7 cycles late with an identical bit pattern.
- Assert RST_n low during the parity bit → line goes to 1 without waiting for CLK, Busy = 0, no Done pulse. A new 0x5A request afterwards transmits correctly.
